// File: rtl/im_fetch_port_pkg.sv
// Shared types for the instruction fetch port: fault codes, response record
// and the fault-priority rule.
package im_pkg;

    localparam int unsigned IM_INSTR_W = 32;

    typedef enum logic [1:0] {
        IM_OK       = 2'b00,
        IM_MISALIGN = 2'b01,
        IM_RANGE    = 2'b10
    } im_fault_e;

    typedef struct packed {
        logic [IM_INSTR_W-1:0] instr;
        im_fault_e             fault;
    } im_resp_t;

    // Misalignment outranks out-of-range when both apply.
    function automatic im_fault_e im_fault_prio(input logic misalign, input logic range_err);
        if (misalign) begin
            return IM_MISALIGN;
        end
        if (range_err) begin
            return IM_RANGE;
        end
        return IM_OK;
    endfunction

endpackage

// File: rtl/im_fetch_port_if.sv
// Fetch request/response handshake bundle between the fetch stage (master)
// and the instruction memory (slave).
interface im_fetch_port_if
    import im_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IM_INSTR_W-1:0] resp_instr;
    im_fault_e             resp_fault;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_instr, resp_fault
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_instr, resp_fault
    );
endinterface

// File: rtl/im_fetch_port_fifo.sv
// Response FIFO: circular buffer of arbitrary depth, same-cycle push/pop,
// synchronous clear and an occupancy count.
module im_resp_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; validity is carried by count_q.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/im_fetch_port.sv
// Instruction memory fetch port: registered byte-addressed read, fault tagging,
// response FIFO with flush, and a byte loader port for program images.
module im_fetch_port
    import im_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MEM_BYTES  = 400,
    parameter string       INIT_FILE  = "imemoria.txt",
    parameter bit          BIG_ENDIAN = 1'b1,
    parameter bit          ALIGN_CHK  = 1'b1,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    im_fetch_port_if.slave    bus,
    input  logic              flush,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data
);

    localparam int unsigned MIDX_W = $clog2(MEM_BYTES);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W  = CNT_W + 1;
    localparam int unsigned RESP_W = $bits(im_resp_t);

    logic [7:0] mem [MEM_BYTES];

    logic                  inflight_q, inflight_d;
    logic [IM_INSTR_W-1:0] instr_q, instr_d;
    im_fault_e             fault_q, fault_d;

    logic                  accept;
    logic                  misalign, range_err;
    im_fault_e             req_fault;
    logic [MIDX_W-1:0]     base;
    logic [7:0]            b0, b1, b2, b3;
    logic [IM_INSTR_W-1:0] rd_word;

    logic                  fifo_push, fifo_pop, fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [OCC_W-1:0]      occ;
    im_resp_t              fifo_din, fifo_dout;
    logic [RESP_W-1:0]     fifo_rdata;

    // Range check is one bit wider than the address so addr+3 cannot wrap.
    assign misalign  = ALIGN_CHK && (bus.req_addr[1:0] != 2'b00);
    assign range_err = {1'b0, bus.req_addr} > (ADDR_W + 1)'(MEM_BYTES - 4);
    assign req_fault = im_fault_prio(misalign, range_err);

    always_comb begin
        base = bus.req_addr[MIDX_W-1:0];
        b0   = mem[base];
        b1   = mem[base + MIDX_W'(1)];
        b2   = mem[base + MIDX_W'(2)];
        b3   = mem[base + MIDX_W'(3)];
        rd_word = BIG_ENDIAN ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
    end

    assign occ      = OCC_W'(fifo_count) + OCC_W'(inflight_q);
    assign fifo_pop = bus.resp_valid && bus.resp_ready;
    // resp_ready reaches req_ready combinationally so a full FIFO can still stream.
    assign bus.req_ready = !rst && !flush &&
                           ((occ < OCC_W'(FIFO_DEPTH)) || fifo_pop);
    assign accept = bus.req_valid && bus.req_ready;

    always_comb begin
        inflight_d = accept;
        instr_d    = instr_q;
        fault_d    = fault_q;
        if (accept) begin
            fault_d = req_fault;
            instr_d = (req_fault == IM_OK) ? rd_word : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            instr_q    <= '0;
            fault_q    <= IM_OK;
        end else begin
            inflight_q <= inflight_d;
            instr_q    <= instr_d;
            fault_q    <= fault_d;
        end
    end

    // Loader writes land after the read above samples, giving read-first order.
    always_ff @(posedge clk) begin
        if (ld_we && ({1'b0, ld_addr} < (ADDR_W + 1)'(MEM_BYTES))) begin
            mem[ld_addr[MIDX_W-1:0]] <= ld_data;
        end
    end

    assign fifo_push = inflight_q && !flush;
    assign fifo_din  = '{instr: instr_q, fault: fault_q};
    assign fifo_dout = im_resp_t'(fifo_rdata);

    im_resp_fifo #(
        .WIDTH (RESP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.resp_valid = !fifo_empty;
    assign bus.resp_instr = bus.resp_valid ? fifo_dout.instr : '0;
    assign bus.resp_fault = bus.resp_valid ? fifo_dout.fault : IM_OK;

endmodule

// File: tb/tb_im_fetch_port.sv
// Directed bench for im_fetch_port: ordering, latency, faults, backpressure,
// flush, loader read-first and mid-stream reset.
module tb_im_fetch_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [7:0]  ld_data;

    int n_checks = 0;
    int n_fail   = 0;
    bit overflow_seen = 1'b0;

    always #5 clk = ~clk;

    im_fetch_port_if #(.ADDR_W(32)) bus ();
    im_fetch_port_if #(.ADDR_W(32)) bus_na ();

    im_fetch_port #(
        .ADDR_W(32), .MEM_BYTES(400), .INIT_FILE(""),
        .BIG_ENDIAN(1'b1), .ALIGN_CHK(1'b1), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .flush(flush),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    im_fetch_port #(
        .ADDR_W(32), .MEM_BYTES(400), .INIT_FILE(""),
        .BIG_ENDIAN(1'b1), .ALIGN_CHK(1'b0), .FIFO_DEPTH(2)
    ) dut_na (
        .clk(clk), .rst(rst), .bus(bus_na), .flush(flush),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    // Pushing into a full FIFO without a simultaneous pop must never happen.
    always @(negedge clk) begin
        if (!rst && dut.fifo_push && (dut.fifo_count == 2'd2) && !dut.fifo_pop)
            overflow_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [31:0] a, input logic [7:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_we = 1'b0;
    endtask

    // One request accepted on the first edge, pushed to the FIFO on the second.
    task automatic fetch_one(input logic [31:0] a);
        bus.req_valid = 1'b1; bus.req_addr = a;
        tick();
        bus.req_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b1; bus.req_addr = 32'h0;
        #1;
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", bus.req_ready); end
        tick();
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
        n_checks++; if (bus.resp_instr !== 32'h0) begin n_fail++; $display("FAIL rst_resp_instr: got %h want 00000000", bus.resp_instr); end
        n_checks++; if (bus.resp_fault !== 2'b00) begin n_fail++; $display("FAIL rst_resp_fault: got %b want 00", bus.resp_fault); end
        bus.req_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        bus.resp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_addr = 32'd0;
        #1;
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %b want 1", bus.req_ready); end
        tick();
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_latency: got valid %b want 0 after one edge", bus.resp_valid); end
        bus.req_addr = 32'd4;
        #1;
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %b want 1", bus.req_ready); end
        tick();
        bus.req_valid = 1'b0;
        n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_instr !== 32'h01020304) begin n_fail++; $display("FAIL b2b_first: got v=%b %h want v=1 01020304", bus.resp_valid, bus.resp_instr); end
        n_checks++; if (bus.resp_fault !== 2'b00) begin n_fail++; $display("FAIL b2b_fault0: got %b want 00", bus.resp_fault); end
        tick();
        n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_instr !== 32'h05060708) begin n_fail++; $display("FAIL b2b_second: got v=%b %h want v=1 05060708", bus.resp_valid, bus.resp_instr); end
        tick();
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got valid %b want 0", bus.resp_valid); end
    endtask

    task automatic test_faults();
        bus.resp_ready = 1'b1;
        fetch_one(32'd2);
        n_checks++; if (bus.resp_instr !== 32'h0 || bus.resp_fault !== 2'b01) begin n_fail++; $display("FAIL misalign_2: got %h/%b want 00000000/01", bus.resp_instr, bus.resp_fault); end
        tick();
        fetch_one(32'd396);
        n_checks++; if (bus.resp_instr !== 32'hA1A2A3A4 || bus.resp_fault !== 2'b00) begin n_fail++; $display("FAIL edge_396: got %h/%b want a1a2a3a4/00", bus.resp_instr, bus.resp_fault); end
        tick();
        fetch_one(32'd397);
        n_checks++; if (bus.resp_instr !== 32'h0 || bus.resp_fault !== 2'b01) begin n_fail++; $display("FAIL misalign_397: got %h/%b want 00000000/01", bus.resp_instr, bus.resp_fault); end
        tick();
        fetch_one(32'hFFFF_FFFC);
        n_checks++; if (bus.resp_instr !== 32'h0 || bus.resp_fault !== 2'b10) begin n_fail++; $display("FAIL range_nowrap: got %h/%b want 00000000/10", bus.resp_instr, bus.resp_fault); end
        tick();
    endtask

    task automatic test_range_noalign();
        bus_na.resp_ready = 1'b1;
        bus_na.req_valid = 1'b1; bus_na.req_addr = 32'd397;
        tick();
        bus_na.req_valid = 1'b0;
        tick();
        n_checks++; if (bus_na.resp_valid !== 1'b1 || bus_na.resp_instr !== 32'h0 || bus_na.resp_fault !== 2'b10) begin n_fail++; $display("FAIL range_397: got v=%b %h/%b want v=1 00000000/10", bus_na.resp_valid, bus_na.resp_instr, bus_na.resp_fault); end
        tick();
        bus_na.req_valid = 1'b1; bus_na.req_addr = 32'd400;
        tick();
        bus_na.req_valid = 1'b0;
        tick();
        n_checks++; if (bus_na.resp_instr !== 32'h0 || bus_na.resp_fault !== 2'b10) begin n_fail++; $display("FAIL range_400: got %h/%b want 00000000/10", bus_na.resp_instr, bus_na.resp_fault); end
        tick();
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        logic [31:0] addrs [3] = '{32'd0, 32'd4, 32'd8};
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = addrs[accepted];
            #1;
            if (bus.req_ready) accepted++;
            tick();
        end
        bus.req_addr = 32'd8;
        #1;
        n_checks++; if (accepted != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d want 2", accepted); end
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got ready %b want 0", bus.req_ready); end
        bus.resp_ready = 1'b1;
        #1;
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_comb_ready: got %b want 1", bus.req_ready); end
        n_checks++; if (bus.resp_instr !== 32'h01020304) begin n_fail++; $display("FAIL bp_order0: got %h want 01020304", bus.resp_instr); end
        tick();
        bus.req_valid = 1'b0;
        n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_instr !== 32'h05060708) begin n_fail++; $display("FAIL bp_order1: got v=%b %h want v=1 05060708", bus.resp_valid, bus.resp_instr); end
        tick();
        n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_instr !== 32'h090A0B0C) begin n_fail++; $display("FAIL bp_order2: got v=%b %h want v=1 090a0b0c", bus.resp_valid, bus.resp_instr); end
        tick();
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_nodup: got valid %b want 0", bus.resp_valid); end
    endtask

    task automatic test_flush();
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_addr = 32'd0;
        tick();
        bus.req_addr = 32'd4;
        tick();
        bus.req_addr = 32'd12;
        flush = 1'b1;
        #1;
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", bus.req_ready); end
        tick();
        flush = 1'b0;
        bus.req_valid = 1'b0;
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_clear: got valid %b want 0", bus.resp_valid); end
        bus.resp_ready = 1'b1;
        fetch_one(32'd8);
        n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_instr !== 32'h090A0B0C) begin n_fail++; $display("FAIL flush_after: got v=%b %h want v=1 090a0b0c", bus.resp_valid, bus.resp_instr); end
        tick();
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_only_one: got valid %b want 0", bus.resp_valid); end
    endtask

    task automatic test_read_first();
        bus.resp_ready = 1'b1;
        ld_we = 1'b1; ld_addr = 32'd0; ld_data = 8'hFF;
        bus.req_valid = 1'b1; bus.req_addr = 32'd0;
        tick();
        ld_we = 1'b0;
        bus.req_valid = 1'b0;
        tick();
        n_checks++; if (bus.resp_instr !== 32'h01020304) begin n_fail++; $display("FAIL rf_old: got %h want 01020304", bus.resp_instr); end
        tick();
        fetch_one(32'd0);
        n_checks++; if (bus.resp_instr !== 32'hFF020304) begin n_fail++; $display("FAIL rf_new: got %h want ff020304", bus.resp_instr); end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_addr = 32'd4;
        tick();
        bus.req_addr = 32'd8;
        tick();
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.resp_valid !== 1'b0 || bus.resp_instr !== 32'h0 || bus.resp_fault !== 2'b00) begin n_fail++; $display("FAIL rstmid_out: got v=%b %h/%b want v=0 00000000/00", bus.resp_valid, bus.resp_instr, bus.resp_fault); end
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b want 0", bus.req_ready); end
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_lost: got valid %b want 0", bus.resp_valid); end
        bus.resp_ready = 1'b1;
        fetch_one(32'd396);
        n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_instr !== 32'hA1A2A3A4) begin n_fail++; $display("FAIL rstmid_first: got v=%b %h want v=1 a1a2a3a4", bus.resp_valid, bus.resp_instr); end
        tick();
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_single: got valid %b want 0", bus.resp_valid); end
    endtask

    task automatic test_no_overflow();
        n_checks++; if (overflow_seen !== 1'b0) begin n_fail++; $display("FAIL fifo_overflow: got push-when-full %b want 0", overflow_seen); end
    endtask

    initial begin
        flush = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.resp_ready = 1'b0;
        bus_na.req_valid = 1'b0; bus_na.req_addr = '0; bus_na.resp_ready = 1'b1;
        test_reset();
        for (int i = 0; i < 12; i++) load_byte(32'(i), 8'(i + 1));
        for (int i = 0; i < 4; i++) load_byte(32'(396 + i), 8'(8'hA1 + i));
        test_back_to_back();
        test_faults();
        test_range_noalign();
        test_backpressure();
        test_flush();
        test_read_first();
        test_reset_mid();
        test_no_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
